dmem_delay_ctrl: RTL and testbench
==================================

DMEM_DELAY_CTRL -- requirements
Module: dmem_delay_ctrl

Interface
REQ-001 The block SHALL expose parameter LATENCY, default 4, meaning the number of BUSY cycles per access; legal range 1..15.
REQ-002 The block SHALL expose parameter DEPTH, default 64, meaning the number of 32-bit words in the data array; power of two, 4..1024.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 MemReadM  input  1  memory-stage load request.
REQ-007 MemWriteM  input  1  memory-stage store request.
REQ-008 ALUOutM  input  32  byte address produced by the execute-stage ALU.
REQ-009 WriteDataM  input  32  store data.
REQ-010 ReadDataM  output  32  load result, registered.
REQ-011 MemStallM  output  1  freezes the F/D/E/M pipeline registers while high.
REQ-012 MemDoneM  output  1  one-cycle pulse marking access completion.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-014 Request = MemReadM | MemWriteM; if both are high, the access SHALL be treated as a write.
REQ-015 In IDLE with request high, MemStallM SHALL be 1 combinationally in that cycle, and at the next edge the block SHALL latch op, address and WriteDataM, load counter = LATENCY-1, and enter BUSY.
REQ-016 In IDLE with no request, MemStallM SHALL be 0 and the state SHALL be held.
REQ-017 In BUSY, MemStallM SHALL be 1; the counter SHALL decrement each cycle while nonzero; at the edge ending the cycle where the counter is 0, the access SHALL be performed and the state SHALL go to DONE.
REQ-018 The write access SHALL store the latched data; the read access SHALL load ReadDataM from the latched word index.
REQ-019 In DONE, MemStallM SHALL be 0, MemDoneM SHALL be 1, and the next state SHALL be IDLE unconditionally; a request visible in DONE belongs to the completed instruction and SHALL be ignored.
REQ-020 Per access, MemStallM SHALL be high for exactly LATENCY+1 consecutive cycles, followed by one DONE cycle.
REQ-021 Back-to-back memory instructions SHALL each incur the full sequence with no overlap; the minimum spacing is LATENCY+2 cycles.
REQ-022 Word index SHALL be ALUOutM[log2(DEPTH)+1:2]; bits [1:0] SHALL be ignored (no misalignment trap); higher bits SHALL be ignored (address wraps modulo DEPTH words).
REQ-023 Input changes during BUSY SHALL NOT affect the access in progress; the latched values SHALL be used.
REQ-024 ReadDataM SHALL hold its value through writes and idle cycles until the next read completes.
REQ-025 Array contents SHALL change only on a completed write access.

Reset
REQ-026 Asserting reset SHALL immediately force state=IDLE, counter=0, ReadDataM=0, MemDoneM=0, and clear the latched op/address/data registers.
REQ-027 While reset is asserted, MemStallM SHALL be 0 regardless of the request inputs.
REQ-028 Reset during BUSY SHALL abort the access, and a pending write SHALL NOT modify the array.
REQ-029 Array contents SHALL NOT be cleared by reset.
REQ-030 After reset deasserts, the first edge SHALL sample requests in IDLE.

Verification
REQ-031 Scenario: LATENCY=4, store 0xDEADBEEF to 0x10, then load from 0x10 -> MemStallM high 5 cycles per access, MemDoneM pulses, ReadDataM=0xDEADBEEF in the load's DONE cycle.
REQ-032 Scenario: LATENCY=1, load with ALUOutM=0x13 after storing 0x12345678 at 0x10 -> stall 2 cycles, ReadDataM=0x12345678 (low bits ignored).
REQ-033 Scenario: DEPTH=64, store 0xA5A5A5A5 to 0x100, load from 0x000 -> ReadDataM=0xA5A5A5A5 (wrap).
REQ-034 Scenario: change ALUOutM and WriteDataM during BUSY of a store to 0x20 -> only word 0x20 is written, with the originally latched data.
REQ-035 Scenario: assert reset in the second BUSY cycle of a store of 0x55 to 0x30 -> MemStallM=0 immediately, FSM in IDLE, a later load of 0x30 returns the pre-store value.
REQ-036 Scenario: MemReadM and MemWriteM both high with 0x77 to 0x40 -> write performed, ReadDataM unchanged, MemDoneM pulses once.

Source files
------------

// File: rtl/dmem_delay_ctrl.sv
// Multi-cycle data memory: each load/store stalls the pipeline for LATENCY+1
// cycles, then completes with a one-cycle DONE pulse.
module dmem_delay_ctrl #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH   = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemStallM,
   output logic        MemDoneM
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [1:0]    nextState;
   logic [3:0]    count;
   logic          opWrite;
   logic [AW-1:0] addrIdx;
   logic [31:0]   dataLat;
   logic [31:0]   mem [DEPTH];
   logic          request;
   logic          accessNow;
   logic          addrUnused;

   assign request    = MemReadM | MemWriteM;
   assign accessNow  = (state == BUSY) && (count == '0);
   // Byte-offset and out-of-range address bits are deliberately dropped.
   assign addrUnused = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (request) nextState = BUSY;
         BUSY:    if (count == '0) nextState = DONE;
         default: nextState = IDLE;
      endcase
   end

   // Stall is forced low while reset is held, even with a request pending.
   always_comb begin
      MemStallM = reset && ((state == BUSY) || ((state == IDLE) && request));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         opWrite   <= 1'b0;
         addrIdx   <= '0;
         dataLat   <= '0;
         ReadDataM <= '0;
         MemDoneM  <= 1'b0;
      end else begin
         state    <= nextState;
         MemDoneM <= accessNow;
         if ((state == IDLE) && request) begin
            opWrite <= MemWriteM;
            addrIdx <= ALUOutM[AW+1:2];
            dataLat <= WriteDataM;
            count   <= 4'(LATENCY - 1);
         end else if ((state == BUSY) && (count != '0)) begin
            count <= count - 4'd1;
         end
         if (accessNow && !opWrite) begin
            ReadDataM <= mem[addrIdx];
         end
      end
   end

   // Array has no reset; an aborted access never reaches accessNow.
   always_ff @(posedge clk) begin
      if (accessNow && opWrite) begin
         mem[addrIdx] <= dataLat;
      end
   end

endmodule

// File: tb/tb_dmem_delay_ctrl.sv
// Randomized bench for dmem_delay_ctrl against a transaction-level memory model.
module tb_dmem_delay_ctrl;

   localparam int unsigned LAT = 4;
   localparam int unsigned DEP = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM;
   logic        MemWriteM;
   logic [31:0] ALUOutM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        MemStallM;
   logic        MemDoneM;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] refMem [DEP];
   logic [31:0] refRead;

   dmem_delay_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .ALUOutM    (ALUOutM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .MemStallM  (MemStallM),
      .MemDoneM   (MemDoneM)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned wordOf(input logic [31:0] a);
      return (a / 4) % DEP;
   endfunction

   // One complete access; inputs are scrambled while the block is stalled.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
      int unsigned stallCycles;
      bit          done;
      @(posedge clk); #1;
      MemReadM   = rd;
      MemWriteM  = wr;
      ALUOutM    = addr;
      WriteDataM = data;
      #1;
      checkVal("stall_idle", 32'(MemStallM), 32'd1);
      stallCycles = 1;
      done        = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(posedge clk); #1;
         if (MemStallM) begin
            stallCycles++;
            MemReadM   = 1'($urandom_range(0, 1));
            MemWriteM  = 1'($urandom_range(0, 1));
            ALUOutM    = $urandom;
            WriteDataM = $urandom;
         end else begin
            done = 1'b1;
         end
      end
      checkVal("done_reached", 32'(done), 32'd1);
      checkVal("stall_len", stallCycles, LAT + 1);
      checkVal("done_pulse", 32'(MemDoneM), 32'd1);
      if (wr) refMem[wordOf(addr)] = data;
      else    refRead = refMem[wordOf(addr)];
      checkVal("read_data", ReadDataM, refRead);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      @(posedge clk); #1;
      checkVal("idle_stall", 32'(MemStallM), 32'd0);
      checkVal("idle_done", 32'(MemDoneM), 32'd0);
      checkVal("read_hold", ReadDataM, refRead);
   endtask

   task automatic abortedStore(input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      MemReadM   = 1'b0;
      MemWriteM  = 1'b1;
      ALUOutM    = addr;
      WriteDataM = data;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkVal("abort_busy2_stall", 32'(MemStallM), 32'd1);
      reset = 1'b0;
      #1;
      checkVal("abort_stall", 32'(MemStallM), 32'd0);
      checkVal("abort_read", ReadDataM, 32'd0);
      checkVal("abort_done", 32'(MemDoneM), 32'd0);
      refRead = '0;
      @(posedge clk); #1;
      checkVal("abort_hold_stall", 32'(MemStallM), 32'd0);
      @(negedge clk);
      MemWriteM = 1'b0;
      reset     = 1'b1;
      @(posedge clk); #1;
      checkVal("abort_idle", 32'(MemStallM), 32'd0);
   endtask

   initial begin
      int unsigned kind;
      reset      = 1'b0;
      MemReadM   = 1'b1;
      MemWriteM  = 1'b1;
      ALUOutM    = 32'h40;
      WriteDataM = 32'h1;
      refRead    = '0;
      #1;
      checkVal("rst_stall", 32'(MemStallM), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_stall_held", 32'(MemStallM), 32'd0);
      checkVal("rst_read", ReadDataM, 32'd0);
      checkVal("rst_done", 32'(MemDoneM), 32'd0);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < int'(DEP); i++) begin
         access(1'b0, 1'b1, 32'(i * 4), $urandom);
      end

      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      access(1'b1, 1'b0, 32'h10, 32'h0);
      access(1'b0, 1'b1, 32'h10, 32'h12345678);
      access(1'b1, 1'b0, 32'h13, 32'h0);
      access(1'b0, 1'b1, 32'h100, 32'hA5A5A5A5);
      access(1'b1, 1'b0, 32'h000, 32'h0);
      access(1'b0, 1'b1, 32'h20, 32'h13572468);
      access(1'b1, 1'b0, 32'h20, 32'h0);
      access(1'b1, 1'b0, 32'h24, 32'h0);
      access(1'b1, 1'b1, 32'h40, 32'h77);
      access(1'b1, 1'b0, 32'h40, 32'h0);
      abortedStore(32'h30, 32'h55);
      access(1'b1, 1'b0, 32'h30, 32'h0);

      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 2);
         access(kind != 1, kind != 0, $urandom, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
